bin_to_bcd_seq: RTL and testbench

//   Sequential binary-to-BCD converter using the shift-add-3 (double-dabble) method.

---
 rtl/bin_to_bcd_seq_if.sv | 24 ++
 rtl/bin_to_bcd_seq.sv | 95 +++++++++
 tb/tb_bin_to_bcd_seq.sv | 184 ++++++++++++++++++
 3 files changed

// File: rtl/bin_to_bcd_seq_if.sv
// bin_to_bcd_seq_if
//   Request/result bundle for the sequential binary-to-BCD converter.
//   master : requester side (drives START/BIN, observes status and result)
//   slave  : converter side
//   START  conversion request, sampled on the rising clock edge
//   BIN    binary value, captured on the accepted START edge
//   BUSY   conversion in progress
//   DONE   one-cycle pulse when BCD/OVF are updated
//   BCD    packed result, digit i in BCD[4i+3:4i], digit 0 = units
//   OVF    last completed input was >= 10**DIGITS
interface bin_to_bcd_seq_if #(
   parameter int unsigned IN_W   = 10,
   parameter int unsigned DIGITS = 4
);
   logic                  START;
   logic [IN_W-1:0]       BIN;
   logic                  BUSY;
   logic                  DONE;
   logic [4*DIGITS-1:0]   BCD;
   logic                  OVF;

   modport master (output START, BIN, input BUSY, DONE, BCD, OVF);
   modport slave  (input START, BIN, output BUSY, DONE, BCD, OVF);
endinterface

// File: rtl/bin_to_bcd_seq.sv
// bin_to_bcd_seq
//   Iterative shift-add-3 (double-dabble) binary-to-BCD converter feeding the
//   7-segment digit decoders. One input bit is consumed per clock; a result
//   is produced every IN_W+1 cycles when START is held high.
//   CLOCK_50  system clock, rising edge
//   RST_N     asynchronous active-low reset
//   cv        slave side of bin_to_bcd_seq_if (START, BIN, BUSY, DONE, BCD, OVF)
module bin_to_bcd_seq #(
   parameter int unsigned IN_W   = 10,
   parameter int unsigned DIGITS = 4
) (
   input  logic             CLOCK_50,
   input  logic             RST_N,
   bin_to_bcd_seq_if.slave  cv
);

   localparam int unsigned   CW   = $clog2(IN_W + 1);
   localparam int unsigned   BW   = 4 * DIGITS;
   localparam logic [CW-1:0] LAST = CW'(IN_W - 1);

   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_SHIFT = 2'd1;
   localparam logic [1:0] ST_DONE  = 2'd2;

   logic [1:0]      state_q;
   logic [CW-1:0]   count_q;
   logic [IN_W-1:0] bin_q;
   logic [BW-1:0]   dig_q;
   logic            sticky_q;
   logic [BW-1:0]   bcd_q;
   logic            ovf_q;

   logic [BW-1:0]   dig_adj;
   logic [BW-1:0]   dig_shifted;
   logic            carry_out;

   // Add-3 correction on every digit in parallel, then shift the next input
   // bit into the units digit. The bit leaving the top digit is a carry into
   // a digit that does not exist, i.e. the value has reached 10**DIGITS.
   always_comb begin
      dig_adj = '0;
      for (int unsigned i = 0; i < DIGITS; i++) begin
         if (dig_q[4*i +: 4] >= 4'd5) dig_adj[4*i +: 4] = dig_q[4*i +: 4] + 4'd3;
         else                         dig_adj[4*i +: 4] = dig_q[4*i +: 4];
      end
      dig_shifted = {dig_adj[BW-2:0], bin_q[IN_W-1]};
      carry_out   = dig_adj[BW-1];
   end

   always_ff @(posedge CLOCK_50 or negedge RST_N) begin
      if (!RST_N) begin
         state_q  <= ST_IDLE;
         count_q  <= '0;
         bin_q    <= '0;
         dig_q    <= '0;
         sticky_q <= 1'b0;
         bcd_q    <= '0;
         ovf_q    <= 1'b0;
      end else begin
         case (state_q)
            ST_IDLE, ST_DONE: begin
               if (cv.START) begin
                  state_q  <= ST_SHIFT;
                  bin_q    <= cv.BIN;
                  dig_q    <= '0;
                  sticky_q <= 1'b0;
                  count_q  <= '0;
               end else begin
                  state_q  <= ST_IDLE;
               end
            end
            ST_SHIFT: begin
               dig_q    <= dig_shifted;
               bin_q    <= bin_q << 1;
               sticky_q <= sticky_q | carry_out;
               count_q  <= count_q + CW'(1);
               // Result registers load on the same edge as the final shift so
               // BCD/OVF never expose a partial value.
               if (count_q == LAST) begin
                  state_q <= ST_DONE;
                  bcd_q   <= dig_shifted;
                  ovf_q   <= sticky_q | carry_out;
               end
            end
            default: state_q <= ST_IDLE;
         endcase
      end
   end

   assign cv.BUSY = (state_q == ST_SHIFT);
   assign cv.DONE = (state_q == ST_DONE);
   assign cv.BCD  = bcd_q;
   assign cv.OVF  = ovf_q;

endmodule

// File: tb/tb_bin_to_bcd_seq.sv
// tb_bin_to_bcd_seq
//   Directed bench for bin_to_bcd_seq. Two instances share clock, reset and
//   request: a 4-digit and a 3-digit converter, both with a 10-bit input.
module tb_bin_to_bcd_seq;

   localparam int unsigned IN_W = 10;
   localparam int          LAT  = 11;   // edges from request setup to DONE

   logic clk;
   logic rst_n;

   bin_to_bcd_seq_if #(.IN_W(IN_W), .DIGITS(4)) cv4 ();
   bin_to_bcd_seq_if #(.IN_W(IN_W), .DIGITS(3)) cv3 ();

   assign cv3.START = cv4.START;
   assign cv3.BIN   = cv4.BIN;

   bin_to_bcd_seq #(.IN_W(IN_W), .DIGITS(4)) u_dut4 (
      .CLOCK_50 (clk),
      .RST_N    (rst_n),
      .cv       (cv4)
   );

   bin_to_bcd_seq #(.IN_W(IN_W), .DIGITS(3)) u_dut3 (
      .CLOCK_50 (clk),
      .RST_N    (rst_n),
      .cv       (cv3)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_err = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Independent reference: digit i = (v / 10**i) % 10.
   function automatic logic [31:0] ref_bcd(input int v, input int nd);
      logic [31:0] r;
      int p;
      r = '0;
      p = 1;
      for (int i = 0; i < nd; i++) begin
         r = r | (32'((v / p) % 10) << (4 * i));
         p = p * 10;
      end
      return r;
   endfunction

   // Waits (bounded) for DONE; returns edges counted from the request setup.
   task automatic wait_done(output int edges);
      edges = 1;
      while (!cv4.DONE && edges < 40) begin
         @(negedge clk);
         edges++;
      end
   endtask

   task automatic convert(input int v, input logic [15:0] e4, input logic eo4,
                          input logic [11:0] e3, input logic eo3, input string tag);
      int edges;
      @(negedge clk);
      cv4.BIN   = IN_W'(v);
      cv4.START = 1'b1;
      @(negedge clk);
      cv4.START = 1'b0;
      check({tag, " busy"}, 32'(cv4.BUSY), 32'd1);
      wait_done(edges);
      check({tag, " latency"}, 32'(edges), 32'(LAT));
      check({tag, " done3"}, 32'(cv3.DONE), 32'd1);
      check({tag, " bcd4"}, 32'(cv4.BCD), 32'(e4));
      check({tag, " ovf4"}, 32'(cv4.OVF), 32'(eo4));
      check({tag, " bcd3"}, 32'(cv3.BCD), 32'(e3));
      check({tag, " ovf3"}, 32'(cv3.OVF), 32'(eo3));
      check({tag, " busy@done"}, 32'(cv4.BUSY), 32'd0);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int edges;
      int dones;

      cv4.START = 1'b0;
      cv4.BIN   = '0;
      rst_n     = 1'b0;
      repeat (3) @(negedge clk);
      check("reset busy", 32'(cv4.BUSY), 32'd0);
      check("reset done", 32'(cv4.DONE), 32'd0);
      check("reset bcd4", 32'(cv4.BCD), 32'd0);
      check("reset ovf4", 32'(cv4.OVF), 32'd0);
      check("reset bcd3", 32'(cv3.BCD), 32'd0);
      rst_n = 1'b1;

      // Basic directed values (3-digit view in the last two arguments).
      convert(0,    16'h0000, 1'b0, 12'h000, 1'b0, "zero");
      convert(1023, 16'h1023, 1'b0, 12'h023, 1'b1, "max");
      convert(599,  16'h0599, 1'b0, 12'h599, 1'b0, "599");
      convert(9,    16'h0009, 1'b0, 12'h009, 1'b0, "nine");
      convert(999,  16'h0999, 1'b0, 12'h999, 1'b0, "999");
      convert(1000, 16'h1000, 1'b0, 12'h000, 1'b1, "1000");

      // START held high, BIN advanced on each DONE.
      @(negedge clk);
      cv4.BIN   = 10'd1;
      cv4.START = 1'b1;
      @(negedge clk);
      for (int k = 1; k <= 3; k++) begin
         wait_done(edges);
         check($sformatf("b2b%0d period", k), 32'(edges), 32'(LAT));
         check($sformatf("b2b%0d bcd", k), 32'(cv4.BCD), 32'(k));
         cv4.BIN = IN_W'(k + 1);
         if (k == 3) cv4.START = 1'b0;
         @(negedge clk);
      end
      check("b2b stop busy", 32'(cv4.BUSY), 32'd0);

      // START pulses and BIN changes during SHIFT are ignored.
      @(negedge clk);
      cv4.BIN   = 10'd599;
      cv4.START = 1'b1;
      @(negedge clk);
      cv4.START = 1'b0;
      edges = 1;
      while (!cv4.DONE && edges < 40) begin
         cv4.START = (edges == 3 || edges == 7);
         if (edges == 3) cv4.BIN = 10'd77;
         @(negedge clk);
         edges++;
      end
      cv4.START = 1'b0;
      check("ignore latency", 32'(edges), 32'(LAT));
      check("ignore bcd", 32'(cv4.BCD), 32'h0599);
      dones = 0;
      repeat (15) begin
         @(negedge clk);
         if (cv4.DONE) dones++;
      end
      check("ignore extra done", 32'(dones), 32'd0);
      check("ignore idle", 32'(cv4.BUSY), 32'd0);

      // Reset mid-conversion aborts and clears the result.
      @(negedge clk);
      cv4.BIN   = 10'd1023;
      cv4.START = 1'b1;
      @(negedge clk);
      cv4.START = 1'b0;
      repeat (4) @(negedge clk);
      rst_n = 1'b0;
      #1;
      check("abort busy", 32'(cv4.BUSY), 32'd0);
      check("abort bcd", 32'(cv4.BCD), 32'd0);
      check("abort done", 32'(cv4.DONE), 32'd0);
      dones = 0;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      repeat (14) begin
         @(negedge clk);
         if (cv4.DONE || cv4.BUSY) dones++;
      end
      check("abort no activity", 32'(dones), 32'd0);
      convert(42, 16'h0042, 1'b0, 12'h042, 1'b0, "after abort");

      // Full input range against the reference model.
      for (int v = 0; v < 1024; v++)
         convert(v, 16'(ref_bcd(v, 4)), 1'b0, 12'(ref_bcd(v, 3)), (v >= 1000),
                 $sformatf("sweep %0d", v));

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
